// File: rtl/aap_pipeline_pkg.sv
// Shared AAP pipeline definitions.
// Widths, the long-instruction flag bit and fetch state encoding.
package aap_pipeline_pkg;

  localparam int AAP_ADDR_WIDTH = 6;
  localparam int AAP_WORD_WIDTH = 16;
  localparam int AAP_LONG_BIT   = 15;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_RUN   = 2'd1,
    FETCH_DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/aap_fetch_outreg.sv
// Valid/ready output register between fetch and decode.
// Flush beats load; a handshake without a load empties it.
module aap_fetch_outreg
  import aap_pipeline_pkg::*;
#(
  parameter int ADDR_WIDTH = AAP_ADDR_WIDTH,
  parameter int INSN_WIDTH = 2 * AAP_WORD_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  flush,
  input  logic                  ready,
  input  logic [INSN_WIDTH-1:0] insn_d,
  input  logic                  is_long_d,
  input  logic [ADDR_WIDTH-1:0] pc_d,
  output logic                  valid,
  output logic [INSN_WIDTH-1:0] insn,
  output logic                  is_long,
  output logic [ADDR_WIDTH-1:0] pc
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid   <= 1'b0;
      insn    <= '0;
      is_long <= 1'b0;
      pc      <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid   <= 1'b1;
      insn    <= insn_d;
      is_long <= is_long_d;
      pc      <= pc_d;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/aap_fetch_stage.sv
// AAP fetch stage: PC, start/halt FSM, 16/32-bit assembly.
// Feeds decode through a valid/ready output register.
module aap_fetch_stage
  import aap_pipeline_pkg::*;
#(
  parameter int ADDR_WIDTH = AAP_ADDR_WIDTH,
  parameter int WORD_WIDTH = AAP_WORD_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    halt,
  input  logic                    branch_valid,
  input  logic [ADDR_WIDTH-1:0]   branch_target,
  output logic [ADDR_WIDTH-1:0]   imem_rd1_addr,
  output logic [ADDR_WIDTH-1:0]   imem_rd2_addr,
  input  logic [WORD_WIDTH-1:0]   imem_rd1_data,
  input  logic [WORD_WIDTH-1:0]   imem_rd2_data,
  output logic                    fetch_valid,
  input  logic                    decode_ready,
  output logic [2*WORD_WIDTH-1:0] fetch_insn,
  output logic                    fetch_is_long,
  output logic [ADDR_WIDTH-1:0]   fetch_pc,
  output logic [COUNT_WIDTH-1:0]  fetch_count,
  output logic                    running
);

  fetch_state_e          state;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  handshake;
  logic                  load;
  logic                  is_long_d;
  logic [2*WORD_WIDTH-1:0] insn_d;

  assign imem_rd1_addr = pc;
  assign imem_rd2_addr = pc + ADDR_WIDTH'(1);

  assign handshake = fetch_valid && decode_ready;
  assign load = (state == FETCH_RUN) && !halt && !branch_valid
             && (!fetch_valid || decode_ready);

  assign is_long_d = imem_rd1_data[AAP_LONG_BIT];
  assign insn_d = is_long_d ? {imem_rd2_data, imem_rd1_data}
                            : {{WORD_WIDTH{1'b0}}, imem_rd1_data};

  assign running = (state != FETCH_IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= FETCH_IDLE;
      pc    <= RESET_PC;
    end else if (branch_valid) begin
      // Redirect wins; a flushed drain has nothing left to wait for
      pc <= branch_target;
      unique case (state)
        FETCH_IDLE:  state <= start ? FETCH_RUN : FETCH_IDLE;
        FETCH_RUN:   state <= halt ? FETCH_IDLE : FETCH_RUN;
        default:     state <= FETCH_IDLE;
      endcase
    end else begin
      unique case (state)
        FETCH_IDLE: begin
          if (start) state <= FETCH_RUN;
        end
        FETCH_RUN: begin
          if (halt) begin
            state <= (fetch_valid && !decode_ready) ? FETCH_DRAIN
                                                    : FETCH_IDLE;
          end else if (load) begin
            pc <= pc + (is_long_d ? ADDR_WIDTH'(2) : ADDR_WIDTH'(1));
          end
        end
        FETCH_DRAIN: begin
          if (handshake) state <= FETCH_IDLE;
        end
        default: state <= FETCH_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) fetch_count <= '0;
    else if (handshake && !branch_valid) fetch_count <= fetch_count + 1'b1;
  end

  aap_fetch_outreg #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INSN_WIDTH (2 * WORD_WIDTH)
  ) u_outreg (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .flush     (branch_valid),
    .ready     (decode_ready),
    .insn_d    (insn_d),
    .is_long_d (is_long_d),
    .pc_d      (pc),
    .valid     (fetch_valid),
    .insn      (fetch_insn),
    .is_long   (fetch_is_long),
    .pc        (fetch_pc)
  );

endmodule
